// File: rtl/ifetch_pq.sv
// ifetch_pq -- instruction-fetch unit with a prefetch queue.
//
// Issues sequential reads to a synchronous instruction memory (fixed 1-cycle
// read latency) ahead of consumption and buffers {pc, insn} pairs in a
// circular queue.  Decode pops the head over a valid/ready handshake.  A
// redirect flushes all speculative state and restarts fetch at a new PC.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   redirect_valid flush and restart fetch at redirect_pc
//   redirect_pc    new fetch address (low alignment bits ignored)
//   imem_req       memory read strobe
//   imem_addr      memory read address
//   imem_rdata     read data, valid the cycle after imem_req
//   out_valid      queue head valid
//   out_ready      decode accepts head
//   out_insn       head instruction (0 when empty)
//   out_pc         head PC (0 when empty)
//
// Optional feature (define IFETCH_PERF_EN):
//   perf_fetch     saturating count of pops
//   perf_redirect  saturating count of redirect cycles
//   perf_stall     saturating count of cycles with out_valid & ~out_ready
module ifetch_pq #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ILEN       = 32,
  parameter logic [XLEN-1:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     INSN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_insn,
  output logic [XLEN-1:0] out_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch,
  output logic [31:0]     perf_redirect,
  output logic [31:0]     perf_stall
`endif
);

  localparam int unsigned     PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW         = PW + 1;
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            kill;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [ILEN-1:0] q_insn [DEPTH];

  logic            pop;
  logic            push;
  logic [CW:0]     occupancy;

  // Credit check counts the entry being popped this cycle as already free,
  // so a full queue with out_ready high keeps fetching at one per cycle.
  always_comb begin
    out_valid = (count != '0);
    pop       = out_valid & out_ready;
    push      = inflight & ~kill & ~redirect_valid;
    occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    imem_req  = rst & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
    imem_addr = fpc;
    out_pc    = out_valid ? q_pc[rd_ptr]   : '0;
    out_insn  = out_valid ? q_insn[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc      <= PC_RESET;
      req_pc   <= PC_RESET;
      inflight <= 1'b0;
      kill     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      kill     <= redirect_valid & inflight;
      if (redirect_valid) begin
        fpc    <= redirect_pc & ~ALIGN_MASK;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (imem_req) begin
          fpc    <= fpc + STEP;
          req_pc <= fpc;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_insn[wr_ptr] <= imem_rdata;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch    <= '0;
      perf_redirect <= '0;
      perf_stall    <= '0;
    end else begin
      if (pop && (perf_fetch != '1))
        perf_fetch <= perf_fetch + 32'd1;
      if (redirect_valid && (perf_redirect != '1))
        perf_redirect <= perf_redirect + 32'd1;
      if (out_valid && !out_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
